// File: rtl/exe_ctrl_pkg.sv
// rtl/exe_ctrl_pkg.sv - shared constants, control word and state encoding for the EX stage controller
package exe_ctrl_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADDU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_BR_EX      = 2'd1,
    ST_BR_RESOLVE = 2'd2
  } state_e;

  // ID/EX control word; alu_enable doubles as the "not a bubble" marker
  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_control;
    logic       reg_dst;
    logic       alu_enable;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Instructions whose rt field is a source operand (not a destination)
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/exe_ctrl_decoder.sv
// rtl/exe_ctrl_decoder.sv - combinational opcode/funct to EX control word decoder
module exe_decoder
  import exe_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic [5:0] id_funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Decode one instruction; unsupported encodings collapse to a bubble
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    illegal = 1'b0;
    if (id_valid) begin
      case (id_opcode)
        OP_RTYPE: begin
          ctrl.alu_src    = 1'b0;
          ctrl.reg_dst    = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.alu_enable = 1'b1;
          case (id_funct)
            FN_ADD:          ctrl.alu_control = ALU_ADD;
            FN_ADDU:         ctrl.alu_control = ALU_ADDU;
            FN_AND:          ctrl.alu_control = ALU_AND;
            FN_OR:           ctrl.alu_control = ALU_OR;
            FN_NOR:          ctrl.alu_control = ALU_NOR;
            FN_SUB, FN_SUBU: ctrl.alu_control = ALU_SUB;
            default: begin
              ctrl    = CTRL_BUBBLE;
              illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI, OP_ANDI, OP_ORI: begin
          ctrl.alu_src     = 1'b1;
          ctrl.reg_write   = 1'b1;
          ctrl.alu_enable  = 1'b1;
          ctrl.alu_control = (id_opcode == OP_ADDI) ? ALU_ADD :
                             (id_opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        end
        OP_LW: begin
          ctrl.alu_src     = 1'b1;
          ctrl.alu_control = ALU_ADD;
          ctrl.mem_read    = 1'b1;
          ctrl.reg_write   = 1'b1;
          ctrl.alu_enable  = 1'b1;
        end
        OP_SW: begin
          ctrl.alu_src     = 1'b1;
          ctrl.alu_control = ALU_ADD;
          ctrl.mem_write   = 1'b1;
          ctrl.alu_enable  = 1'b1;
        end
        OP_BEQ: begin
          ctrl.alu_control = ALU_SUB;
          ctrl.branch      = 1'b1;
          ctrl.alu_enable  = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_ctrl.sv
// rtl/exe_stage_ctrl.sv - EX stage controller: ID/EX control register, load-use and branch sequencing, stats
module exe_stage_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [5:0]       id_funct,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             zero_flag,
  output logic             alu_src,
  output logic [2:0]       alu_control,
  output logic             reg_dst,
  output logic             alu_enable,
  output logic             mem_read_ex,
  output logic             mem_write_ex,
  output logic             reg_write_ex,
  output logic             branch_ex,
  output logic [4:0]       ex_rt,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e           state_q, state_d;
  ctrl_t            ex_ctrl_q, ex_ctrl_d;
  logic [4:0]       ex_rt_q, ex_rt_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  logic             load_use;
  logic             accept_id;

  exe_decoder u_decoder (
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .id_funct  (id_funct),
    .ctrl      (dec_ctrl),
    .illegal   (dec_illegal)
  );

  // Load-use hazard: only meaningful in RUN, where EX may hold a real lw
  always_comb begin
    load_use = 1'b0;
    if (state_q == ST_RUN && id_valid && ex_ctrl_q.mem_read && ex_rt_q != 5'd0) begin
      load_use = (ex_rt_q == id_rs) || (uses_rt(id_opcode) && ex_rt_q == id_rt);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next-state: a beq entering EX from RUN starts the two-step resolve sequence
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN:        state_d = (!load_use && dec_ctrl.branch) ? ST_BR_EX : ST_RUN;
      ST_BR_EX:      state_d = ST_BR_RESOLVE;
      ST_BR_RESOLVE: state_d = ST_RUN;
      default:       state_d = ST_RUN;
    endcase
  end

  // Pipeline steering outputs derived from state, hazard and the branch outcome
  always_comb begin
    pc_stall   = 1'b0;
    ifid_flush = 1'b0;
    pc_src     = 1'b0;
    case (state_q)
      ST_RUN:        pc_stall = load_use;
      ST_BR_EX:      pc_stall = 1'b1;
      ST_BR_RESOLVE: begin
        ifid_flush = zero_flag;
        pc_src     = zero_flag;
      end
      default: ;
    endcase
    ifid_stall = pc_stall;
    accept_id  = !pc_stall && !ifid_flush;
  end

  // ID/EX next contents and saturating statistics
  always_comb begin
    ex_ctrl_d   = accept_id ? dec_ctrl : CTRL_BUBBLE;
    ex_rt_d     = (accept_id && dec_ctrl.alu_enable) ? id_rt : 5'd0;
    illegal_d   = accept_id && dec_illegal;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // ID/EX register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q   <= CTRL_BUBBLE;
      ex_rt_q     <= 5'd0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rt_q     <= ex_rt_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign alu_src      = ex_ctrl_q.alu_src;
  assign alu_control  = ex_ctrl_q.alu_control;
  assign reg_dst      = ex_ctrl_q.reg_dst;
  assign alu_enable   = ex_ctrl_q.alu_enable;
  assign mem_read_ex  = ex_ctrl_q.mem_read;
  assign mem_write_ex = ex_ctrl_q.mem_write;
  assign reg_write_ex = ex_ctrl_q.reg_write;
  assign branch_ex    = ex_ctrl_q.branch;
  assign ex_rt        = ex_rt_q;
  assign illegal      = illegal_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// tb/tb_exe_stage_ctrl.sv - self-checking bench for exe_stage_ctrl
module tb_exe_stage_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [5:0]       id_funct;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             zero_flag;
  logic             alu_src;
  logic [2:0]       alu_control;
  logic             reg_dst;
  logic             alu_enable;
  logic             mem_read_ex;
  logic             mem_write_ex;
  logic             reg_write_ex;
  logic             branch_ex;
  logic [4:0]       ex_rt;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             pc_src;
  logic             illegal;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always #5 clk = ~clk;

  exe_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_funct     (id_funct),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .zero_flag    (zero_flag),
    .alu_src      (alu_src),
    .alu_control  (alu_control),
    .reg_dst      (reg_dst),
    .alu_enable   (alu_enable),
    .mem_read_ex  (mem_read_ex),
    .mem_write_ex (mem_write_ex),
    .reg_write_ex (reg_write_ex),
    .branch_ex    (branch_ex),
    .ex_rt        (ex_rt),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .pc_src       (pc_src),
    .illegal      (illegal),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // EX-side observation bus: {alu_src, alu_control, reg_dst, alu_enable, mem_read, mem_write, reg_write, branch, illegal}
  logic [10:0] obs;
  assign obs = {alu_src, alu_control, reg_dst, alu_enable, mem_read_ex,
                mem_write_ex, reg_write_ex, branch_ex, illegal};

  typedef struct {
    string       name;
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [10:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] sb_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt);
    id_valid  = v;
    id_opcode = op;
    id_funct  = fn;
    id_rs     = rs;
    id_rt     = rt;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input string n, input logic v, input logic [5:0] op,
                              input logic [5:0] fn, input logic [10:0] e);
    vec_t r;
    r.name = n; r.valid = v; r.op = op; r.fn = fn; r.exp = e;
    return r;
  endfunction

  initial begin
    vecs.push_back(mk("add",     1, 6'b000000, 6'b100000, 11'b0_000_1_1_0_0_1_0_0));
    vecs.push_back(mk("addu",    1, 6'b000000, 6'b100001, 11'b0_100_1_1_0_0_1_0_0));
    vecs.push_back(mk("and",     1, 6'b000000, 6'b100100, 11'b0_001_1_1_0_0_1_0_0));
    vecs.push_back(mk("or",      1, 6'b000000, 6'b100101, 11'b0_010_1_1_0_0_1_0_0));
    vecs.push_back(mk("nor",     1, 6'b000000, 6'b100111, 11'b0_011_1_1_0_0_1_0_0));
    vecs.push_back(mk("sub",     1, 6'b000000, 6'b100010, 11'b0_101_1_1_0_0_1_0_0));
    vecs.push_back(mk("subu",    1, 6'b000000, 6'b100011, 11'b0_101_1_1_0_0_1_0_0));
    vecs.push_back(mk("bad_fn",  1, 6'b000000, 6'b000000, 11'b0_000_0_0_0_0_0_0_1));
    vecs.push_back(mk("addi",    1, 6'b001000, 6'b000000, 11'b1_000_0_1_0_0_1_0_0));
    vecs.push_back(mk("andi",    1, 6'b001100, 6'b000000, 11'b1_001_0_1_0_0_1_0_0));
    vecs.push_back(mk("ori",     1, 6'b001101, 6'b000000, 11'b1_010_0_1_0_0_1_0_0));
    vecs.push_back(mk("lw",      1, 6'b100011, 6'b000000, 11'b1_000_0_1_1_0_1_0_0));
    vecs.push_back(mk("sw",      1, 6'b101011, 6'b000000, 11'b1_000_0_1_0_1_0_0_0));
    vecs.push_back(mk("beq",     1, 6'b000100, 6'b000000, 11'b0_101_0_1_0_0_0_1_0));
    vecs.push_back(mk("bad_op",  1, 6'b111111, 6'b000000, 11'b0_000_0_0_0_0_0_0_1));
    vecs.push_back(mk("invalid", 0, 6'b111111, 6'b000000, 11'b0_000_0_0_0_0_0_0_0));

    rst_n = 1'b0;
    zero_flag = 1'b0;
    idle();
    step();
    step();
    check("reset_obs", obs, 0);
    check("reset_steer", {pc_stall, ifid_stall, ifid_flush, pc_src}, 0);
    check("reset_cnts", {stall_cnt, flush_cnt}, 0);
    rst_n = 1'b1;
    step();

    // Decode sweep, one instruction at a time with idle cycles to drain branches
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].fn, 5'd1, 5'd2);
      sb_q.push_back(vecs[i].exp);
      step();
      check({"dec_", vecs[i].name}, obs, sb_q.pop_front());
      idle();
      step();
      check({"illegal_pulse_", vecs[i].name}, illegal, 0);
      step();
      step();
    end

    // Load-use: lw rt=5 followed by add rs=5 stalls exactly once
    do_reset();
    drive(1, 6'b100011, 6'd0, 5'd1, 5'd5);
    step();
    check("lu_ex_rt", ex_rt, 5);
    drive(1, 6'b000000, 6'b100000, 5'd5, 5'd2);
    #1;
    check("lu_stall", {pc_stall, ifid_stall}, 2'b11);
    step();
    check("lu_bubble", alu_enable, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    #1;
    check("lu_stall_once", pc_stall, 0);
    step();
    check("lu_add_in_ex", {alu_enable, alu_control, reg_dst}, 5'b1_000_1);
    idle();
    step();

    // Load-use with rt=0 must not stall
    drive(1, 6'b100011, 6'd0, 5'd1, 5'd0);
    step();
    drive(1, 6'b000000, 6'b100000, 5'd0, 5'd2);
    #1;
    check("lu0_no_stall", pc_stall, 0);
    step();
    check("lu0_add_in_ex", {alu_enable, reg_dst, mem_read_ex}, 3'b110);
    check("lu0_stall_cnt", stall_cnt, 1);
    idle();
    step();

    // Branch taken
    do_reset();
    drive(1, 6'b000100, 6'd0, 5'd1, 5'd2);
    step();
    check("bt_branch_ex", branch_ex, 1);
    drive(1, 6'b000000, 6'b100000, 5'd3, 5'd4);
    #1;
    check("bt_stall", {pc_stall, ifid_stall, pc_src, ifid_flush}, 4'b1100);
    step();
    check("bt_bubble1", alu_enable, 0);
    check("bt_stall_cnt", stall_cnt, 1);
    zero_flag = 1'b1;
    #1;
    check("bt_flush", {pc_stall, ifid_stall, pc_src, ifid_flush}, 4'b0011);
    step();
    check("bt_bubble2", alu_enable, 0);
    check("bt_flush_cnt", flush_cnt, 1);
    check("bt_run_steer", {pc_src, ifid_flush, pc_stall}, 0);
    zero_flag = 1'b0;
    step();
    check("bt_after", {alu_enable, alu_control, reg_dst}, 5'b1_000_1);
    idle();
    step();

    // Branch not taken: next instruction reaches EX three cycles after beq was driven
    do_reset();
    drive(1, 6'b000100, 6'd0, 5'd1, 5'd2);
    step();
    drive(1, 6'b001101, 6'd0, 5'd3, 5'd4);
    step();
    check("bn_bubble", alu_enable, 0);
    #1;
    check("bn_steer", {pc_stall, pc_src, ifid_flush}, 0);
    step();
    check("bn_ori_in_ex", {alu_enable, alu_control, alu_src, reg_dst}, 6'b1_010_1_0);
    check("bn_cnts", {stall_cnt, flush_cnt}, {4'd1, 4'd0});
    idle();
    step();

    // Reset in BR_RESOLVE drops steering immediately and returns to RUN
    do_reset();
    drive(1, 6'b000100, 6'd0, 5'd1, 5'd2);
    step();
    idle();
    step();
    zero_flag = 1'b1;
    #1;
    check("rb_pre", pc_src, 1);
    rst_n = 1'b0;
    #1;
    check("rb_steer", {pc_src, ifid_flush, pc_stall, ifid_stall}, 0);
    check("rb_obs", obs, 0);
    check("rb_cnts", {stall_cnt, flush_cnt}, 0);
    rst_n = 1'b1;
    step();
    #1;
    check("rb_run", {pc_src, ifid_flush}, 0);
    zero_flag = 1'b0;
    step();

    // Saturation: 20 load-use hazards on a 4-bit counter
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1, 6'b100011, 6'd0, 5'd1, 5'd5);
      step();
      drive(1, 6'b000000, 6'b100000, 5'd5, 5'd2);
      step();
      step();
    end
    check("sat_stall_cnt", stall_cnt, 15);
    check("sat_flush_cnt", flush_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
